// File: rtl/rl_action_sched_if.sv
// Stream and compare-unit handshake bundle for rl_action_sched.
// The scheduler takes the master modport; the environment takes the slave modport.
interface rl_action_sched_if #(
  parameter int W     = 16,
  parameter int IDX_W = 2
);
  logic [W-1:0]     s_axis_q_tdata;
  logic             s_axis_q_tvalid;
  logic             s_axis_q_tready;
  logic [W-1:0]     cmp_a_tdata;
  logic             cmp_a_tvalid;
  logic [W-1:0]     cmp_b_tdata;
  logic             cmp_b_tvalid;
  logic             cmp_result_tvalid;
  logic             cmp_index;
  logic             cmp_equal;
  logic [IDX_W-1:0] m_axis_act_tdata;
  logic             m_axis_act_tvalid;
  logic             m_axis_act_tready;

  modport master (
    input  s_axis_q_tdata, s_axis_q_tvalid,
    output s_axis_q_tready,
    output cmp_a_tdata, cmp_a_tvalid, cmp_b_tdata, cmp_b_tvalid,
    input  cmp_result_tvalid, cmp_index, cmp_equal,
    output m_axis_act_tdata, m_axis_act_tvalid,
    input  m_axis_act_tready
  );

  modport slave (
    output s_axis_q_tdata, s_axis_q_tvalid,
    input  s_axis_q_tready,
    input  cmp_a_tdata, cmp_a_tvalid, cmp_b_tdata, cmp_b_tvalid,
    output cmp_result_tvalid, cmp_index, cmp_equal,
    input  m_axis_act_tdata, m_axis_act_tvalid,
    output m_axis_act_tready
  );
endinterface

// File: rtl/rl_action_sched.sv
// Sequential argmax over one buffered Q-vector using a shared external compare unit.
// Define RL_EXPLORE_EN to add epsilon-greedy exploration (eps_thresh in, m_axis_act_explore out).
//
// state    | meaning
// S_LOAD   | accepting Q-values into the buffer
// S_ISSUE  | one-cycle compare issue of buf[best_idx] vs buf[cand]
// S_WAIT   | waiting for the compare result or the timeout
// S_UPDATE | advance to the next candidate or finish
// S_DONE   | holding the selected action until accepted
module rl_action_sched #(
  parameter int EXP         = 5,
  parameter int FRA         = 10,
  parameter int N_ACT       = 4,
  parameter int IDX_W       = 2,
  parameter int CMP_TIMEOUT = 64
) (
  input  logic               aclk,
  input  logic               aresetn,
  rl_action_sched_if.master  bus,
`ifdef RL_EXPLORE_EN
  input  logic [7:0]         eps_thresh,
  output logic               m_axis_act_explore,
`endif
  output logic               busy,
  output logic               timeout_err
);
  localparam int W   = EXP + FRA + 1;
  localparam int WCW = $clog2(CMP_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ACT - 1);

  typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, best_idx, cand, out_idx, pick_idx;
  logic [WCW-1:0]   wait_cnt;
  logic [W-1:0]     q_buf [N_ACT];
  logic             load_beat, issue, tmo, done_entry, pick_explore;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_beat = 1'b0;
    issue     = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      S_LOAD: begin
        load_beat = bus.s_axis_q_tvalid;
        if (bus.s_axis_q_tvalid && cnt == LAST) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        issue     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the last allowed cycle beats the timeout
        if (bus.cmp_result_tvalid) begin
          state_nxt = S_UPDATE;
        end else if (wait_cnt == WCW'(CMP_TIMEOUT - 1)) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_UPDATE: state_nxt = (cand == LAST) ? S_DONE : S_ISSUE;
      S_DONE:   if (bus.m_axis_act_tready) state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  assign done_entry = (state != S_DONE) && (state_nxt == S_DONE);

  always_ff @(posedge aclk) begin
    if (load_beat) q_buf[cnt] <= bus.s_axis_q_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt         <= '0;
      best_idx    <= '0;
      cand        <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load_beat) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == '0) timeout_err <= 1'b0;
        if (cnt == LAST) begin
          best_idx <= '0;
          cand     <= IDX_W'(1);
        end
      end
      if (issue) wait_cnt <= '0;
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        // ties and A>B keep the incumbent, so equal values resolve to the lower index
        if (bus.cmp_result_tvalid && !bus.cmp_equal && !bus.cmp_index) best_idx <= cand;
      end
      if (tmo) timeout_err <= 1'b1;
      if (state == S_UPDATE && cand != LAST) cand <= cand + 1'b1;
      if (state == S_DONE && bus.m_axis_act_tready) cnt <= '0;
    end
  end

`ifdef RL_EXPLORE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign pick_explore = (lfsr[15:8] < eps_thresh) && (32'(lfsr[IDX_W-1:0]) < N_ACT);
  assign pick_idx     = pick_explore ? lfsr[IDX_W-1:0] : best_idx;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr               <= 16'hACE1;
      m_axis_act_explore <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      if (done_entry) m_axis_act_explore <= pick_explore;
    end
  end
`else
  assign pick_explore = 1'b0;
  assign pick_idx     = best_idx;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)        out_idx <= '0;
    else if (done_entry) out_idx <= pick_idx;
  end

  assign bus.s_axis_q_tready   = (state == S_LOAD);
  assign bus.cmp_a_tvalid      = issue;
  assign bus.cmp_b_tvalid      = issue;
  assign bus.cmp_a_tdata       = issue ? q_buf[best_idx] : '0;
  assign bus.cmp_b_tdata       = issue ? q_buf[cand] : '0;
  assign bus.m_axis_act_tvalid = (state == S_DONE);
  assign bus.m_axis_act_tdata  = out_idx;
  assign busy = !((state == S_LOAD) && (cnt == '0));
endmodule

// File: tb/tb_rl_action_sched.sv
// Directed plus randomized bench for rl_action_sched with a half-float compare-unit model.
module tb_rl_action_sched;
  localparam int N   = 4;
  localparam int TMO = 64;

  typedef logic [15:0] vec_t [N];

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  int   cmp_lat = 12;
  int   stall_at = 0;
  int   issue_total = 0;
  int   last_issue_cyc = 0;
  int   late_req = 0;
  int   late_done = 0;

  rl_action_sched_if #(.W(16), .IDX_W(2)) bus ();

`ifdef RL_EXPLORE_EN
  logic [7:0] eps_thresh = 8'h00;
  logic       explore;
`endif
  logic busy, timeout_err;

  rl_action_sched #(.EXP(5), .FRA(10), .N_ACT(N), .IDX_W(2), .CMP_TIMEOUT(TMO)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
`ifdef RL_EXPLORE_EN
    .eps_thresh         (eps_thresh),
    .m_axis_act_explore (explore),
`endif
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  f = int'(h[9:0]);
    real m;
    if (e == 0) m = (f / 1024.0) * (2.0 ** -14);
    else        m = (1.0 + f / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -m : m;
  endfunction

  function automatic int argmax(input vec_t v, input int n);
    int b = 0;
    for (int i = 1; i < n; i++) if (h2r(v[i]) > h2r(v[b])) b = i;
    return b;
  endfunction

  // compare unit: result L cycles after the issue, optional stall, late-pulse on request
  initial begin
    int          ctr;
    bit          pend;
    logic [15:0] ca, cb;
    pend = 0; ctr = 0; ca = '0; cb = '0;
    bus.cmp_result_tvalid = 1'b0;
    bus.cmp_index = 1'b0;
    bus.cmp_equal = 1'b0;
    forever begin
      @(negedge aclk);
      bus.cmp_result_tvalid = 1'b0;
      if (!aresetn) begin
        pend = 0;
      end else begin
        if (pend) begin
          ctr--;
          if (ctr == 0) begin
            pend = 0;
            bus.cmp_result_tvalid = 1'b1;
            bus.cmp_index = h2r(ca) > h2r(cb);
            bus.cmp_equal = h2r(ca) == h2r(cb);
          end
        end
        if (late_req != late_done) begin
          late_done = late_req;
          bus.cmp_result_tvalid = 1'b1;
          bus.cmp_index = 1'b0;
          bus.cmp_equal = 1'b0;
        end
        if (bus.cmp_a_tvalid) begin
          issue_total++;
          last_issue_cyc = cyc;
          ca = bus.cmp_a_tdata;
          cb = bus.cmp_b_tdata;
          if (issue_total != stall_at) begin
            pend = 1;
            ctr  = cmp_lat;
          end
        end
      end
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_vec(input vec_t v, output int last_cyc);
    int g;
    last_cyc = 0;
    for (int i = 0; i < N; i++) begin
      bus.s_axis_q_tdata  = v[i];
      bus.s_axis_q_tvalid = 1'b1;
      g = 0;
      while (!bus.s_axis_q_tready && g < 500) begin
        @(negedge aclk);
        g++;
      end
      if (g >= 500) chk(32'(g), 32'(0), "load_ready_timeout");
      last_cyc = cyc;
      @(negedge aclk);
    end
    bus.s_axis_q_tvalid = 1'b0;
  endtask

  task automatic wait_result(output int d);
    int g = 0;
    while (!bus.m_axis_act_tvalid && g < 3000) begin
      @(negedge aclk);
      g++;
    end
    if (g >= 3000) chk(32'(g), 32'(0), "result_timeout");
    d = cyc;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) v[i] = v[$urandom_range(0, i - 1)];
      else v[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
    end
    return v;
  endfunction

  initial begin
    vec_t v;
    int   b, d, n0, hold_idx;
    bus.s_axis_q_tdata    = '0;
    bus.s_axis_q_tvalid   = 1'b0;
    bus.m_axis_act_tready = 1'b1;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk(32'(bus.m_axis_act_tvalid), 0, "rst_tvalid");
    chk(32'(bus.m_axis_act_tdata), 0, "rst_tdata");
    chk(32'(bus.cmp_a_tvalid), 0, "rst_cmp_valid");
    chk(32'(busy), 0, "rst_busy");
    chk(32'(timeout_err), 0, "rst_timeout_err");
    chk(32'(bus.s_axis_q_tready), 1, "rst_q_tready");
    aresetn = 1'b1;
    @(negedge aclk);

    // basic argmax and latency
    cmp_lat = 12;
    v = '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00};
    send_vec(v, b);
    chk(32'(busy), 1, "busy_during_compare");
    wait_result(d);
    chk(32'(bus.m_axis_act_tdata), 1, "basic_tdata");
    chk(32'(d - b), 32'((N - 1) * (12 + 2) + 1), "basic_latency");
    chk(32'(timeout_err), 0, "basic_timeout_err");
    @(negedge aclk);
    chk(32'(bus.m_axis_act_tvalid), 0, "basic_tvalid_drop");
    chk(32'(busy), 0, "basic_idle");

    // ties keep the lower index
    cmp_lat = 3;
    n0 = issue_total;
    v = '{16'h4200, 16'h4200, 16'h3C00, 16'h4200};
    send_vec(v, b);
    wait_result(d);
    chk(32'(bus.m_axis_act_tdata), 0, "tie_tdata");
    chk(32'(issue_total - n0), 3, "tie_issue_count");
    @(negedge aclk);

    // backpressure hold
    bus.m_axis_act_tready = 1'b0;
    v = '{16'hC400, 16'hC200, 16'hC100, 16'hC000};
    send_vec(v, b);
    wait_result(d);
    for (int i = 0; i < 10; i++) begin
      chk(32'(bus.m_axis_act_tvalid), 1, "hold_tvalid");
      chk(32'(bus.m_axis_act_tdata), 3, "hold_tdata");
      chk(32'(bus.s_axis_q_tready), 0, "hold_no_accept");
      @(negedge aclk);
    end
    bus.m_axis_act_tready = 1'b1;
    @(negedge aclk);
    chk(32'(bus.m_axis_act_tvalid), 0, "hold_release");

    // stall on compare 2 -> timeout, late result ignored
    cmp_lat = 5;
    stall_at = issue_total + 2;
    bus.m_axis_act_tready = 1'b0;
    v = rand_vec();
    send_vec(v, b);
    wait_result(d);
    chk(32'(timeout_err), 1, "tmo_flag");
    chk(32'(bus.m_axis_act_tdata), 32'(argmax(v, 2)), "tmo_tdata");
    chk(32'(d - last_issue_cyc), 32'(TMO + 1), "tmo_wait_cycles");
    hold_idx = int'(bus.m_axis_act_tdata);
    late_req++;
    repeat (4) @(negedge aclk);
    chk(32'(late_done), 32'(late_req), "late_pulse_sent");
    chk(32'(bus.m_axis_act_tvalid), 1, "late_tvalid");
    chk(32'(bus.m_axis_act_tdata), 32'(hold_idx), "late_tdata");
    chk(32'(timeout_err), 1, "tmo_sticky");
    bus.m_axis_act_tready = 1'b1;
    @(negedge aclk);
    stall_at = 0;
    v = '{16'h3C00, 16'h3800, 16'h3400, 16'h4000};
    send_vec(v, b);
    chk(32'(timeout_err), 0, "tmo_cleared");
    wait_result(d);
    chk(32'(bus.m_axis_act_tdata), 3, "post_tmo_tdata");
    @(negedge aclk);

    // reset during WAIT
    cmp_lat = 12;
    v = rand_vec();
    send_vec(v, b);
    repeat (5) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    chk(32'(bus.m_axis_act_tvalid), 0, "midrst_tvalid");
    chk(32'(busy), 0, "midrst_busy");
    chk(32'(bus.cmp_a_tvalid), 0, "midrst_cmp_valid");
    aresetn = 1'b1;
    @(negedge aclk);
    v = '{16'h3800, 16'h3C00, 16'h4000, 16'h4400};
    send_vec(v, b);
    wait_result(d);
    chk(32'(bus.m_axis_act_tdata), 3, "midrst_tdata");
    chk(32'(d - b), 32'((N - 1) * (12 + 2) + 1), "midrst_latency");
    @(negedge aclk);

    // random vectors and compare latencies
    for (int k = 0; k < 40; k++) begin
      cmp_lat = $urandom_range(1, 9);
      v = rand_vec();
      send_vec(v, b);
      wait_result(d);
      chk(32'(bus.m_axis_act_tdata), 32'(argmax(v, N)), "rand_tdata");
      chk(32'(d - b), 32'((N - 1) * (cmp_lat + 2) + 1), "rand_latency");
      chk(32'(timeout_err), 0, "rand_timeout_err");
      @(negedge aclk);
    end

`ifdef RL_EXPLORE_EN
    begin
      logic [3:0] seen = '0;
      eps_thresh = 8'h00;
      for (int k = 0; k < 20; k++) begin
        cmp_lat = $urandom_range(1, 4);
        v = rand_vec();
        send_vec(v, b);
        wait_result(d);
        chk(32'(explore), 0, "eps0_explore");
        chk(32'(bus.m_axis_act_tdata), 32'(argmax(v, N)), "eps0_tdata");
        @(negedge aclk);
      end
      eps_thresh = 8'hFF;
      cmp_lat = 1;
      for (int k = 0; k < 1000; k++) begin
        v = rand_vec();
        send_vec(v, b);
        wait_result(d);
        seen[bus.m_axis_act_tdata] = 1'b1;
        chk(32'(explore || (int'(bus.m_axis_act_tdata) == argmax(v, N))), 1, "eps_explore_flag");
        @(negedge aclk);
      end
      chk(32'(seen), 32'hF, "eps_all_indices");
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/rl_action_sched.md
Name: rl_action_sched

Overview:
Sequential argmax scheduler for the RL action-selection path. It buffers one vector of N_ACT half-precision Q-values and time-shares a single external two-input softmax-compare unit. The compare unit has A/B valid inputs, a result valid, an index output (1 = A>B) and an equal output. The block issues N_ACT-1 pairwise compares, tracks the running best, and emits the winning action index on an AXI-stream-style output with backpressure.

Parameters:
EXP, 5, exponent width of Q-values
FRA, 10, fraction width of Q-values (word width EXP+FRA+1)
N_ACT, 4, number of actions per vector (legal range 2..16)
IDX_W, 2, action index width, must equal clog2(N_ACT)
CMP_TIMEOUT, 64, maximum cycles to wait for a compare result

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_axis_q_tdata  in  EXP+FRA+1  Q-value, action 0 first
s_axis_q_tvalid  in  1  Q-value valid
s_axis_q_tready  out  1  high only in LOAD
cmp_a_tdata  out  EXP+FRA+1  current best value
cmp_a_tvalid  out  1  one-cycle issue pulse
cmp_b_tdata  out  EXP+FRA+1  candidate value
cmp_b_tvalid  out  1  same pulse as cmp_a_tvalid
cmp_result_tvalid  in  1  compare result valid
cmp_index  in  1  1 = A>B, 0 = A<B; don't-care when cmp_equal=1
cmp_equal  in  1  A==B
m_axis_act_tdata  out  IDX_W  selected action index
m_axis_act_tvalid  out  1  result valid
m_axis_act_tready  in  1  downstream ready
busy  out  1  high in any state except LOAD with load count 0
timeout_err  out  1  sticky compare-timeout flag

Behaviour:
- Reset (async, aresetn=0): FSM=LOAD, load count=0, all outputs 0, buffer contents don't-care. Reset mid-operation aborts immediately; no partial result is emitted.
- LOAD:
  - s_axis_q_tready=1; each tvalid&tready beat writes buf[cnt] and increments cnt.
  - The first beat of a vector clears timeout_err.
  - After beat N_ACT-1: best_idx=0, cand=1, go to ISSUE.
- ISSUE (1 cycle):
  - cmp_a/b_tvalid=1 with a=buf[best_idx], b=buf[cand].
  - Clear the wait counter; go to WAIT.
- WAIT:
  - Wait counter increments each cycle.
  - On cmp_result_tvalid: if cmp_equal=1 or cmp_index=1, keep best_idx (ties resolve to the lower index); else best_idx=cand. Go to UPDATE.
  - If the counter reaches CMP_TIMEOUT with no result: set timeout_err, go to DONE with the current best_idx.
  - A result and the timeout in the same cycle: the result wins.
- UPDATE (1 cycle): if cand==N_ACT-1 go to DONE, else cand++ and go to ISSUE.
- DONE:
  - m_axis_act_tvalid=1; tdata is registered and stable while valid&!ready.
  - On tready: tvalid drops next cycle, cnt=0, go to LOAD.
- cmp_result_tvalid outside WAIT is ignored, including a late result after a timeout.
- Latency from the last Q beat to tvalid: (N_ACT-1)*(L_cmp+2)+1 cycles, where L_cmp is the compare-unit latency from issue to result.
- Input arrives only in LOAD, so a new vector is never accepted while a result is pending.

Optional Feature:
RL_EXPLORE_EN: epsilon-greedy exploration.
- With the macro defined:
  - Adds input eps_thresh[7:0] and output m_axis_act_explore (1 bit, reset 0, valid with tdata).
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - On entry to DONE: if lfsr[15:8] < eps_thresh and lfsr[IDX_W-1:0] < N_ACT, tdata=lfsr[IDX_W-1:0] and explore=1; otherwise tdata=best_idx and explore=0.
  - eps_thresh=0 never explores.
- Without the macro: neither port exists and output is always best_idx.

Test Plan:
- Q={0x3C00,0x4000,0x3800,0xBC00} (1.0,2.0,0.5,-1.0), compare model latency 12 -> tdata=1, tvalid 3*14+1=43 cycles after the last beat, timeout_err=0.
- Q={0x4200,0x4200,0x3C00,0x4200} -> ties kept: tdata=0; exactly 3 cmp_a_tvalid pulses.
- Winner 0xC000 last in an all-negative vector {0xC400,0xC200,0xC100,0xC000} -> tdata=3; hold tready=0 for 10 cycles -> tvalid and tdata stable; only then accept the next vector.
- Compare model stalls on the 2nd compare -> timeout_err=1 after 64 WAIT cycles, tdata = best after compare 1; a late result is ignored; next vector's first beat clears timeout_err.
- Assert aresetn=0 during WAIT, then feed a new vector {0x3800,0x3C00,0x4000,0x4400} -> no stale output, tdata=3.
- RL_EXPLORE_EN with eps_thresh=0 -> explore=0 always; with eps_thresh=8'hFF over 1000 vectors -> all indices 0..3 appear, explore=1 whenever tdata differs from argmax.
